usb_fs_out_ep_arb: RTL and testbench

Round-robin arbiter that shares the single OUT-endpoint read port of the OUT protocol engine between per-endpoint consumers. It drives the one-hot endpoint grant and gates each consumer's byte-get strobe. It enforces an idle gap between grants so the engine's registered read data never mixes endpoints. It also forces rotation after a configurable burst length so one busy endpoint cannot starve the others.

---
 rtl/usb_fs_out_ep_arb.sv | 122 ++++++++++++
 tb/tb_usb_fs_out_ep_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_out_ep_arb.sv
// Round-robin owner of the OUT-endpoint read port: grants one endpoint at a time,
// gates its byte-get strobes and leaves an idle gap before handing the port on.
module usb_fs_out_ep_arb #(
    parameter int NUM_OUT_EPS = 4,
    parameter int MAX_HOLD    = 32,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_OUT_EPS-1:0] req,
    input  logic [NUM_OUT_EPS-1:0] data_get,
    input  logic [NUM_OUT_EPS-1:0] out_ep_data_avail,
    output logic [NUM_OUT_EPS-1:0] out_ep_grant,
    output logic [NUM_OUT_EPS-1:0] out_ep_data_get,
    output logic [NUM_OUT_EPS-1:0] rd_valid,
    output logic                   busy
);
    localparam int PTR_W  = (NUM_OUT_EPS > 1) ? $clog2(NUM_OUT_EPS) : 1;
    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int GAP_W  = 3;
    localparam logic [PTR_W-1:0]  LAST_EP  = PTR_W'(NUM_OUT_EPS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t                 r_state;
    logic [NUM_OUT_EPS-1:0] r_grant;
    logic [NUM_OUT_EPS-1:0] r_rdValid;
    logic [PTR_W-1:0]       r_ptr;
    logic [HOLD_W-1:0]      r_holdCount;
    logic [GAP_W-1:0]       r_gapCount;
    logic                   r_busy;

    logic                   w_found;
    logic [PTR_W-1:0]       w_winner;
    logic [PTR_W-1:0]       w_scanIdx;
    logic [NUM_OUT_EPS-1:0] w_winnerMask;
    logic                   w_accept;
    logic [HOLD_W-1:0]      w_holdNext;
    logic                   w_othersWaiting;
    logic                   w_releaseA;
    logic                   w_releaseB;

    // Scan upward from the endpoint after the last winner, wrapping once around.
    always_comb begin
        w_found      = 1'b0;
        w_winner     = '0;
        w_winnerMask = '0;
        w_scanIdx    = r_ptr;
        for (int k = 0; k < NUM_OUT_EPS; k++) begin
            w_scanIdx = (w_scanIdx == LAST_EP) ? '0 : w_scanIdx + 1'b1;
            if (!w_found && req[w_scanIdx]) begin
                w_found                 = 1'b1;
                w_winner                = w_scanIdx;
                w_winnerMask[w_scanIdx] = 1'b1;
            end
        end
    end

    assign out_ep_data_get = r_grant & data_get & out_ep_data_avail & req;
    assign w_accept        = |out_ep_data_get;
    assign w_holdNext      = (w_accept && (r_holdCount != HOLD_MAX)) ? r_holdCount + 1'b1 : r_holdCount;
    assign w_othersWaiting = |(req & ~r_grant);
    assign w_releaseA      = ~|(req & r_grant);
    // Counting this cycle's byte lets the owner take exactly MAX_HOLD bytes, the last one in the release cycle.
    assign w_releaseB      = (MAX_HOLD != 0) && (w_holdNext == HOLD_MAX) && w_othersWaiting;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_rdValid   <= '0;
            r_ptr       <= LAST_EP;
            r_holdCount <= '0;
            r_gapCount  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_rdValid <= out_ep_data_get;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_winnerMask;
                        r_ptr       <= w_winner;
                        r_holdCount <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    r_holdCount <= w_holdNext;
                    if (w_releaseA || w_releaseB) begin
                        r_grant    <= '0;
                        r_gapCount <= '0;
                        r_state    <= GAP;
                    end
                end
                GAP: begin
                    if (r_gapCount == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gapCount <= r_gapCount + 1'b1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_ep_grant = r_grant;
    assign rd_valid     = r_rdValid;
    assign busy         = r_busy;
endmodule

// File: tb/tb_usb_fs_out_ep_arb.sv
// Bench for usb_fs_out_ep_arb: directed scenarios plus random traffic, all checked
// against an ownership/byte-count model of the arbiter's rules.
module tb_usb_fs_out_ep_arb;
    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] dataGet;
    logic [N-1:0] avail;
    logic [N-1:0] grant;
    logic [N-1:0] engGet;
    logic [N-1:0] rdValid;
    logic         busy;

    always #5 clk = ~clk;

    usb_fs_out_ep_arb #(
        .NUM_OUT_EPS(N),
        .MAX_HOLD   (HOLD),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .data_get         (dataGet),
        .out_ep_data_avail(avail),
        .out_ep_grant     (grant),
        .out_ep_data_get  (engGet),
        .rd_valid         (rdValid),
        .busy             (busy)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: current owner (-1 = none), remaining gap cycles, bytes taken this grant, last winner.
    int mOwner   = -1;
    int mGapLeft = 0;
    int mBytes   = 0;
    int mLast    = N - 1;
    int mRdValid = 0;
    int lastEngGet = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] g, input logic [N-1:0] a);
        req     = r;
        dataGet = g;
        avail   = a;
    endtask

    function automatic int expGet();
        int r, g, a;
        r = int'(req);
        g = int'(dataGet);
        a = int'(avail);
        if (mOwner < 0) return 0;
        return r & g & a & (1 << mOwner);
    endfunction

    function automatic void modelReset();
        mOwner   = -1;
        mGapLeft = 0;
        mBytes   = 0;
        mLast    = N - 1;
        mRdValid = 0;
    endfunction

    function automatic void modelStep();
        int r, got, c;
        r   = int'(req);
        got = expGet();
        if (mOwner >= 0) begin
            if (got != 0) mBytes++;
            if (((r >> mOwner) & 1) == 0) begin
                mOwner   = -1;
                mGapLeft = GAP;
            end else if (HOLD > 0 && mBytes >= HOLD && (r & ~(1 << mOwner)) != 0) begin
                mOwner   = -1;
                mGapLeft = GAP;
            end
        end else if (mGapLeft > 0) begin
            mGapLeft--;
        end else if (r != 0) begin
            for (int k = 1; k <= N; k++) begin
                c = (mLast + k) % N;
                if (((r >> c) & 1) != 0) begin
                    mOwner = c;
                    mLast  = c;
                    mBytes = 0;
                    break;
                end
            end
        end
        mRdValid = got;
    endfunction

    task automatic compareAll();
        checkOutput("grant", int'(grant), (mOwner >= 0) ? (1 << mOwner) : 0);
        checkOutput("eng_get", int'(engGet), expGet());
        checkOutput("rd_valid", int'(rdValid), mRdValid);
        checkOutput("busy", int'(busy), (mOwner >= 0 || mGapLeft > 0) ? 1 : 0);
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic stepCycle(input logic [N-1:0] r, input logic [N-1:0] g, input logic [N-1:0] a);
        applyStimulus(r, g, a);
        #2;
        compareAll();
        lastEngGet = int'(engGet);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus('0, '0, '0);
        reset = 1'b0;
        #2;
        checkOutput("rst_grant", int'(grant), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_rd_valid", int'(rdValid), 0);
        checkOutput("rst_eng_get", int'(engGet), 0);
        modelReset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int bound;
        logic [N-1:0] reqHold;

        reset = 1'b0;
        applyStimulus('0, '0, '0);
        @(posedge clk);
        #1;
        doReset();

        // Single requester: latency, five fetched bytes, release and gap.
        stepCycle(4'b0100, 4'b0000, 4'b1111);
        checkOutput("single_grant", int'(grant), 4'b0100);
        repeat (5) stepCycle(4'b0100, 4'b0100, 4'b1111);
        repeat (5) stepCycle(4'b0000, 4'b0000, 4'b1111);
        checkOutput("single_idle_busy", int'(busy), 0);

        // All requesting and fetching: rotation every HOLD bytes.
        repeat (40) stepCycle(4'b1111, 4'b1111, 4'b1111);
        repeat (6) stepCycle(4'b0000, 4'b0000, 4'b0000);

        // Forced rotation: ep0 gets exactly HOLD bytes before ep1 takes over.
        doReset();
        cnt   = 0;
        bound = 0;
        while (grant != 4'b0010 && bound < 40) begin
            stepCycle(4'b0011, 4'b0001, 4'b1111);
            cnt += lastEngGet & 1;
            bound++;
        end
        checkOutput("rot_ep1_granted", int'(grant), 4'b0010);
        checkOutput("rot_ep0_bytes", cnt, HOLD);

        // Lone requester keeps fetching past the hold limit.
        cnt = 0;
        repeat (20) begin
            stepCycle(4'b0001, 4'b0001, 4'b1111);
            cnt += lastEngGet & 1;
        end
        checkOutput("solo_past_hold", (cnt > HOLD) ? 1 : 0, 1);

        // Gating during an ep1 grant.
        bound = 0;
        while (grant != 4'b0010 && bound < 12) begin
            stepCycle(4'b0010, 4'b0000, 4'b1111);
            bound++;
        end
        checkOutput("gate_ep1_granted", int'(grant), 4'b0010);
        repeat (3) stepCycle(4'b0010, 4'b0011, 4'b0001);
        checkOutput("gate_rd_valid", int'(rdValid), 0);

        // Asynchronous reset between edges while ep1 holds the port.
        applyStimulus(4'b0010, 4'b0000, 4'b1111);
        #2;
        reset = 1'b0;
        applyStimulus('0, '0, '0);
        #1;
        checkOutput("async_grant", int'(grant), 0);
        checkOutput("async_busy", int'(busy), 0);
        checkOutput("async_eng_get", int'(engGet), 0);
        modelReset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        bound = 0;
        while (grant == '0 && bound < 5) begin
            stepCycle(4'b1010, 4'b0000, 4'b1111);
            bound++;
        end
        checkOutput("post_rst_winner", int'(grant), 4'b0010);
        repeat (4) stepCycle(4'b0000, 4'b0000, 4'b0000);

        // Random traffic with level-style requests.
        reqHold = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) reqHold = reqHold ^ N'(1 << i);
            end
            stepCycle(reqHold, N'($urandom_range(0, (1 << N) - 1)), N'($urandom | $urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
